// File: rtl/pc_sequencer.sv
// PC owner and fetch/decode/update sequencer with req/ack instruction fetch and JAL link write.
// Optional TRAP_SEL_EN: conflicting jr/jump/jal selects vector to TRAP_PC and pulse trap.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic             ctl_valid,
    input  logic             stall,
    input  logic             jump,
    input  logic             jal,
    input  logic             jr,
    input  logic             branch,
    input  logic             br_cond,
    input  logic [25:0]      jump_target,
    input  logic [31:0]      jr_target,
    input  logic [15:0]      br_offset,
    output logic [31:0]      pc,
    output logic             link_we,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_UPDATE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_next_pc;
    logic [31:0]      r_link_addr;
    logic             r_req;
    logic             r_link_we;
    logic             r_trap;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_p1;
    logic [31:0]      w_br_tgt;
    logic [31:0]      w_j_tgt;
    logic [31:0]      w_target;
    logic             w_conflict;
    logic             w_accept;

    assign w_p1     = r_pc + 32'd1;
    assign w_br_tgt = w_p1 + {{16{br_offset[15]}}, br_offset};
    assign w_j_tgt  = {w_p1[31:26], jump_target};
    assign w_accept = (r_state == S_DECODE) && ctl_valid && !stall;

`ifdef TRAP_SEL_EN
    logic [1:0] w_nsel;
    assign w_nsel     = {1'b0, jr} + {1'b0, jump} + {1'b0, jal};
    assign w_conflict = (w_nsel >= 2'd2);
`else
    assign w_conflict = 1'b0;
`endif

    // Fixed priority: trap vector, jr, jump/jal, taken branch, sequential.
    always_comb begin
        w_target = w_p1;
        if (w_conflict)
            w_target = TRAP_PC;
        else if (jr)
            w_target = jr_target;
        else if (jump || jal)
            w_target = w_j_tgt;
        else if (branch && br_cond)
            w_target = w_br_tgt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FETCH:  if (r_req && imem_ack) w_state_nxt = S_DECODE;
            S_DECODE: if (w_accept)          w_state_nxt = S_UPDATE;
            S_UPDATE:                        w_state_nxt = S_FETCH;
            default:                         w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= S_FETCH;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_next_pc   <= RESET_PC;
            r_link_addr <= '0;
            r_req       <= 1'b0;
            r_link_we   <= 1'b0;
            r_trap      <= 1'b0;
            r_count     <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    // req comes up on the first FETCH cycle after reset; UPDATE pre-arms it otherwise.
                    if (!r_req)
                        r_req <= 1'b1;
                    else if (imem_ack)
                        r_req <= 1'b0;
                end
                S_DECODE: begin
                    if (w_accept) begin
                        r_next_pc   <= w_target;
                        r_link_addr <= w_p1;
                        r_link_we   <= jal && !w_conflict;
                        r_trap      <= w_conflict;
                    end
                end
                S_UPDATE: begin
                    r_pc      <= r_next_pc;
                    r_count   <= r_count + CNT_W'(1);
                    r_link_we <= 1'b0;
                    r_trap    <= 1'b0;
                    r_req     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign link_we     = r_link_we;
    assign link_addr   = r_link_addr;
    assign instr_count = r_count;
    assign trap        = r_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: reset, next-PC sources, link, stall, trap and wrap.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        ctl_valid = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        jal = 1'b0;
    logic        jr = 1'b0;
    logic        branch = 1'b0;
    logic        br_cond = 1'b0;
    logic [25:0] jump_target = '0;
    logic [31:0] jr_target = '0;
    logic [15:0] br_offset = '0;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_addr;
    logic [31:0] instr_count;
    logic        trap;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_count = '0;

`ifdef TRAP_SEL_EN
    localparam logic [31:0] CONFLICT_PC   = 32'h0000_0080;
    localparam logic        CONFLICT_TRAP = 1'b1;
`else
    localparam logic [31:0] CONFLICT_PC   = 32'h0000_1234;
    localparam logic        CONFLICT_TRAP = 1'b0;
`endif

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TRAP_PC  (32'h0000_0080),
        .CNT_W    (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .ctl_valid   (ctl_valid),
        .stall       (stall),
        .jump        (jump),
        .jal         (jal),
        .jr          (jr),
        .branch      (branch),
        .br_cond     (br_cond),
        .jump_target (jump_target),
        .jr_target   (jr_target),
        .br_offset   (br_offset),
        .pc          (pc),
        .link_we     (link_we),
        .link_addr   (link_addr),
        .instr_count (instr_count),
        .trap        (trap)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(
        input string       tag,
        input logic [31:0] e_addr,
        input int          ack_dly,
        input int          stall_cyc,
        input logic        v_jr,
        input logic        v_jump,
        input logic        v_jal,
        input logic        v_br,
        input logic        v_cond,
        input logic [25:0] v_jt,
        input logic [31:0] v_jrt,
        input logic [15:0] v_off,
        input logic [31:0] e_next,
        input logic        e_link,
        input logic [31:0] e_link_addr,
        input logic        e_trap
    );
        int waited = 0;
        while (!imem_req && waited < 10) begin
            step();
            waited++;
        end
        check({tag, "_req"}, 64'(imem_req), 64'd1);
        check({tag, "_addr"}, 64'(imem_addr), 64'(e_addr));
        for (int i = 0; i < ack_dly; i++) begin
            step();
            check({tag, "_req_hold"}, 64'(imem_req), 64'd1);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check({tag, "_req_drop"}, 64'(imem_req), 64'd0);
        jr = v_jr; jump = v_jump; jal = v_jal; branch = v_br; br_cond = v_cond;
        jump_target = v_jt; jr_target = v_jrt; br_offset = v_off;
        ctl_valid = 1'b1;
        stall = (stall_cyc > 0);
        for (int i = 0; i < stall_cyc; i++) begin
            step();
            check({tag, "_stall_pc"}, 64'(pc), 64'(e_addr));
            check({tag, "_stall_req"}, 64'(imem_req), 64'd0);
            check({tag, "_stall_lwe"}, 64'(link_we), 64'd0);
        end
        stall = 1'b0;
        step();
        ctl_valid = 1'b0; jr = 1'b0; jump = 1'b0; jal = 1'b0; branch = 1'b0; br_cond = 1'b0;
        check({tag, "_link_we"}, 64'(link_we), 64'(e_link));
        if (e_link)
            check({tag, "_link_addr"}, 64'(link_addr), 64'(e_link_addr));
        check({tag, "_trap"}, 64'(trap), 64'(e_trap));
        check({tag, "_upd_pc"}, 64'(pc), 64'(e_addr));
        step();
        exp_count++;
        check({tag, "_next_pc"}, 64'(imem_addr), 64'(e_next));
        check({tag, "_next_req"}, 64'(imem_req), 64'd1);
        check({tag, "_count"}, 64'(instr_count), 64'(exp_count));
        check({tag, "_lwe_off"}, 64'(link_we), 64'd0);
        check({tag, "_trap_off"}, 64'(trap), 64'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        check("rst_link_we", 64'(link_we), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        reset = 1'b1;
        step();
        check("req_rise", 64'(imem_req), 64'd1);

        //        tag       addr          ack stl jr jmp jal br cnd jt            jrt           off       next          lnk lnk_addr      trap
        run_instr("seq0",   32'h0,        2,  0,  0, 0,  0,  0, 0, 26'h0,        32'h0,        16'h0,    32'h1,        0,  32'h0,        0);
        run_instr("jr10",   32'h1,        0,  0,  1, 0,  0,  0, 0, 26'h0,        32'h10,       16'h0,    32'h10,       0,  32'h0,        0);
        run_instr("brtk",   32'h10,       1,  0,  0, 0,  0,  1, 1, 26'h0,        32'h0,        16'hFFFE, 32'h0F,       0,  32'h0,        0);
        run_instr("jr10b",  32'h0F,       0,  0,  1, 0,  0,  0, 0, 26'h0,        32'h10,       16'h0,    32'h10,       0,  32'h0,        0);
        run_instr("brnt",   32'h10,       0,  0,  0, 0,  0,  1, 0, 26'h0,        32'h0,        16'hFFFE, 32'h11,       0,  32'h0,        0);
        run_instr("jrhi",   32'h11,       0,  0,  1, 0,  0,  0, 0, 26'h0,        32'h0400_0005, 16'h0,   32'h0400_0005, 0, 32'h0,        0);
        run_instr("jal",    32'h0400_0005, 0, 0,  0, 0,  1,  0, 0, 26'h000_0100, 32'h0,        16'h0,    32'h0400_0100, 1, 32'h0400_0006, 0);
        run_instr("conf",   32'h0400_0100, 0, 0,  1, 1,  0,  0, 0, 26'h0,        32'h1234,     16'h0,    CONFLICT_PC,  0,  32'h0,        CONFLICT_TRAP);
        run_instr("jmpbr",  CONFLICT_PC,  0,  0,  0, 1,  0,  1, 1, 26'h3FF_FFFF, 32'h0,        16'h0005, 32'h03FF_FFFF, 0, 32'h0,        0);
        run_instr("jrmax",  32'h03FF_FFFF, 0, 0,  1, 0,  0,  0, 0, 26'h0,        32'hFFFF_FFFF, 16'h0,   32'hFFFF_FFFF, 0, 32'h0,        0);
        run_instr("wrap",   32'hFFFF_FFFF, 0, 0,  0, 0,  0,  0, 0, 26'h0,        32'h0,        16'h0,    32'h0,        0,  32'h0,        0);
        run_instr("stall",  32'h0,        0,  3,  0, 0,  1,  0, 0, 26'h20,       32'h0,        16'h0,    32'h20,       1,  32'h1,        0);

        step();
        check("midf_req", 64'(imem_req), 64'd1);
        reset = 1'b0;
        step();
        check("midf_req_rst", 64'(imem_req), 64'd0);
        check("midf_pc_rst", 64'(pc), 64'd0);
        check("midf_cnt_rst", 64'(instr_count), 64'd0);
        reset = 1'b1;
        exp_count = '0;
        step();
        run_instr("postrst", 32'h0,       1,  0,  0, 0,  0,  0, 0, 26'h0,        32'h0,        16'h0,    32'h1,        0,  32'h0,        0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
